time_keeper_cfg: RTL

- Parametrised successor to the 1 Hz seconds/minutes/hours counter.
- Runs on the system clock with an internal prescaler that generates the 1-second tick.
- Adds run/stop, validated time load, manual minute/hour adjust, 12/24-hour display mapping, and one-cycle rollover pulses.
- Feeds the display mux and the alarm comparator.

---
 rtl/time_keeper_cfg.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/time_keeper_cfg.sv
// Time-of-day counter with an internal 1-second prescaler and run/stop control.
// Also provides validated time load, manual minute/hour adjust, 12/24-hour display and rollover pulses.
module time_keeper_cfg #(
    parameter int TICK_DIV = 100000000,
    parameter int PRE_W    = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       set_valid,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       set_err
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             load_ok;
    logic             adjust;

    logic [5:0] sec_n;
    logic [5:0] min_n;
    logic [4:0] hr_n;
    logic       sp_n;
    logic       mp_n;
    logic       hp_n;
    logic       dp_n;
    logic       err_n;

    assign tick    = run && (pre_cnt == PRE_LAST);
    assign load_ok = (set_hours <= 5'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    assign adjust  = inc_min || inc_hour;

    // A successful load restarts the second so the next tick is a full period away.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            pre_cnt <= '0;
        end else if (set_valid && load_ok) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_comb begin
        sec_n = seconds;
        min_n = minutes;
        hr_n  = hours;
        sp_n  = 1'b0;
        mp_n  = 1'b0;
        hp_n  = 1'b0;
        dp_n  = 1'b0;
        err_n = 1'b0;
        if (set_valid) begin
            if (load_ok) begin
                sec_n = set_seconds;
                min_n = set_minutes;
                hr_n  = set_hours;
            end else begin
                err_n = 1'b1;
            end
        end else if (adjust) begin
            if (inc_min) begin
                min_n = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            end
            if (inc_hour) begin
                hr_n = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end
        end else if (tick) begin
            sp_n = 1'b1;
            if (seconds == 6'd59) begin
                sec_n = 6'd0;
                mp_n  = 1'b1;
                if (minutes == 6'd59) begin
                    min_n = 6'd0;
                    hp_n  = 1'b1;
                    if (hours == 5'd23) begin
                        hr_n = 5'd0;
                        dp_n = 1'b1;
                    end else begin
                        hr_n = hours + 5'd1;
                    end
                end else begin
                    min_n = minutes + 6'd1;
                end
            end else begin
                sec_n = seconds + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            sec_pulse  <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            set_err    <= 1'b0;
        end else begin
            seconds    <= sec_n;
            minutes    <= min_n;
            hours      <= hr_n;
            sec_pulse  <= sp_n;
            min_pulse  <= mp_n;
            hour_pulse <= hp_n;
            day_pulse  <= dp_n;
            set_err    <= err_n;
        end
    end

    always_comb begin
        pm = (hours >= 5'd12);
        if (!mode_12h) begin
            disp_hours = hours;
        end else if (hours == 5'd0) begin
            disp_hours = 5'd12;
        end else if (hours > 5'd12) begin
            disp_hours = hours - 5'd12;
        end else begin
            disp_hours = hours;
        end
    end

endmodule
